mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between two masters: m0 = CPU memory
//  port (MAR address, c_ri/c_ro strobes) and m1 = program loader / debug port.
//  Round-robin arbitration, one transaction at a time, req/ack handshake per master.
//  Sits between the CPU and the RAM; the CPU stalls its cycle clock while m0_req is
//  pending and m0_ack has not been returned.
// PARAMETERS
//  ADDR_W       8  address width, both masters and RAM
//  DATA_W       8  data width
//  RAM_LATENCY  1  cycles from ram_en (read) to valid ram_rdata; legal range 1..4
// PORTS
//  clk        in   1       system clock, all state updates on posedge
//  reset      in   1       asynchronous, active-low; clears all state immediately
//  m0_req     in   1       CPU requests a transaction
//  m0_we      in   1       1 = write, 0 = read
//  m0_addr    in   ADDR_W  CPU address
//  m0_wdata   in   DATA_W  CPU write data
//  m0_ack     out  1       one-cycle pulse: CPU transaction complete
//  m0_rdata   out  DATA_W  last read data for CPU, held until next m0 read
//  m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata  same as m0_*, loader side
//  ram_en     out  1       RAM access strobe, exactly one cycle per transaction
//  ram_we     out  1       RAM write enable, high only together with ram_en
//  ram_addr   out  ADDR_W  RAM address (latched, stable for the whole transaction)
//  ram_wdata  out  DATA_W  RAM write data (latched)
//  ram_rdata  in   DATA_W  RAM read data
//  busy       out  1       high in every state except IDLE
//  owner      out  1       master of current/last transaction (0 = m0, 1 = m1)
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; ram_en, ram_we, m0_ack, m1_ack, busy = 0;
//   m0_rdata, m1_rdata, ram_addr, ram_wdata = 0; owner = 1 (so m0 wins first tie).
//  FSM, 2-bit state:
//   IDLE : sample reqs. None -> IDLE. One -> grant it. Both -> grant !owner.
//          On grant latch we/addr/wdata of winner, set owner, -> ISSUE.
//   ISSUE: ram_en=1, ram_we=latched we. Write -> DONE. Read -> load cnt=RAM_LATENCY-1, -> WAIT.
//   WAIT : if cnt==0 capture ram_rdata into winner's rdata, -> DONE; else cnt--.
//   DONE : winner's ack=1 for this cycle only; -> IDLE.
//  Latency (req sampled in IDLE at cycle 0): write ack at cycle 2; read ack at
//   cycle 2+RAM_LATENCY, rdata valid from the same cycle as ack.
//  Master inputs sampled only in IDLE; changes during a transaction are ignored.
//  req dropped mid-transaction: transaction completes, ack still pulses.
//  req held after ack: new transaction; still subject to round-robin in IDLE.
//  Fairness: with both requesting continuously, grants strictly alternate;
//   a waiting master is delayed by at most one transaction of the other.
//  A write never alters either rdata; the non-owner's rdata never changes.
//  Reset mid-transaction: in-flight access abandoned, no ack issued, back to IDLE.
//  Minimum one IDLE cycle between consecutive transactions.
// STRUCTURE
//  State encodings (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE) added as defines to
//   the shared parameters.v include.
//  Round-robin pick is a small sub-module rr_pick2 (req0, req1, last -> gnt, valid);
//   FSM, latches and latency counter stay in mem_arbiter.
// TESTING
//  1. Reset low mid-test -> all outputs at reset values same cycle; owner=1.
//  2. m0 write addr 0x10 data 0xA5 -> ram_en=ram_we=1 at cycle 1 with 0x10/0xA5,
//     m0_ack at cycle 2, m0_rdata unchanged.
//  3. m1 read 0x10, RAM model returns 0xA5, RAM_LATENCY=1 and 3 -> m1_ack at
//     cycle 3 / 5, m1_rdata=0xA5, ram_we=0.
//  4. m0 and m1 both hold req for 6 transactions from reset -> grant order
//     m0,m1,m0,m1,m0,m1; exactly one ack per transaction.
//  5. m1 drops req during WAIT -> m1_ack still pulses once, then IDLE, busy=0.
//  6. Assert reset during WAIT -> no ack, ram_en stays 0; next m0 read completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
//   ADDR_W / DATA_W : bus widths shared by both masters and the RAM
//   arb_state_e     : arbiter FSM states
//   arb_cmd_t       : latched command of the granted master
//   wait_load()     : latency-counter preload for a given RAM read latency
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    // Holds RAM_LATENCY-1 for the legal latency range 1..4.
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } arb_cmd_t;

    // The counter runs in the WAIT state and expires at zero, so a latency of
    // L needs L-1 extra WAIT cycles after the first.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bus between one master and the arbiter.
//   req   : master requests a transaction (sampled only while the arbiter is idle)
//   we    : 1 = write, 0 = read
//   addr  : transaction address
//   wdata : write data
//   ack   : one-cycle completion pulse
//   rdata : last read data for this master, held until its next read
// Modports: master (drives req/we/addr/wdata), slave (the arbiter side).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick.
//   i_req0 / i_req1 : requests of master 0 / master 1
//   i_last          : master that owned the previous transaction
//   o_gnt           : chosen master (valid only with o_valid)
//   o_valid         : at least one request present
module mem_arbiter_rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_gnt,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        // On a tie the master that did not go last wins.
        o_gnt   = (i_req0 && i_req1) ? ~i_last : i_req1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port RAM between the CPU port (m0) and the loader/debug
// port (m1), one transaction at a time with round-robin arbitration.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   m0_if, m1_if     : master request/ack buses (slave modport)
//   o_ram_en         : RAM access strobe, one cycle per transaction
//   o_ram_we         : RAM write enable, only together with o_ram_en
//   o_ram_addr       : latched RAM address
//   o_ram_wdata      : latched RAM write data
//   i_ram_rdata      : RAM read data, valid RAM_LATENCY cycles after o_ram_en
//   o_busy           : high whenever a transaction is in flight
//   o_owner          : master of the current/last transaction
// RAM_LATENCY legal range is 1..4.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_arbiter_if.slave      m0_if,
    mem_arbiter_if.slave      m1_if,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy,
    output logic              o_owner
);

    arb_state_e        r_state;
    arb_cmd_t          r_cmd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_ram_en;
    logic              r_ram_we;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt;
    logic              w_valid;
    arb_cmd_t          w_cmd;

    mem_arbiter_rr_pick2 u_pick (
        .i_req0  (m0_if.req),
        .i_req1  (m1_if.req),
        .i_last  (r_owner),
        .o_gnt   (w_gnt),
        .o_valid (w_valid)
    );

    // Command of whichever master the picker selected.
    always_comb begin
        if (w_gnt) begin
            w_cmd = '{we: m1_if.we, addr: m1_if.addr, wdata: m1_if.wdata};
        end else begin
            w_cmd = '{we: m0_if.we, addr: m0_if.addr, wdata: m0_if.wdata};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ARB_IDLE;
            r_cmd    <= '0;
            r_cnt    <= '0;
            r_owner  <= 1'b1;  // m0 wins the first tie
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            // Strobes are single-cycle; only the transitions below raise them.
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_owner  <= w_gnt;
                        r_cmd    <= w_cmd;
                        r_ram_en <= 1'b1;
                        r_ram_we <= w_cmd.we;
                        r_state  <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (r_cmd.we) begin
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                        r_state <= ARB_DONE;
                    end else begin
                        r_cnt   <= wait_load(RAM_LATENCY);
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner) begin
                            r_rdata1 <= i_ram_rdata;
                        end else begin
                            r_rdata0 <= i_ram_rdata;
                        end
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                        r_state <= ARB_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_cmd.addr;
    assign o_ram_wdata = r_cmd.wdata;
    assign o_busy      = (r_state != ARB_IDLE);
    assign o_owner     = r_owner;

    assign m0_if.ack   = r_ack0;
    assign m0_if.rdata = r_rdata0;
    assign m1_if.ack   = r_ack1;
    assign m1_if.rdata = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM latency 1 and 3) share one
// stimulus stream; a transaction-level model predicts every output each cycle.
module tb_mem_arbiter;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    logic clk;
    logic rst_n;

    // Stimulus, shared by both instances: index = master.
    logic       s_req   [2];
    logic       s_we    [2];
    logic [7:0] s_addr  [2];
    logic [7:0] s_wdata [2];

    // DUT outputs, index = instance.
    logic       ram_en    [2];
    logic       ram_we    [2];
    logic [7:0] ram_addr  [2];
    logic [7:0] ram_wdata [2];
    logic [7:0] ram_rdata [2];
    logic       busy      [2];
    logic       owner     [2];
    logic       ack0      [2];
    logic       ack1      [2];
    logic [7:0] rdata0    [2];
    logic [7:0] rdata1    [2];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter_if ifa0 ();
    mem_arbiter_if ifa1 ();
    mem_arbiter_if ifb0 ();
    mem_arbiter_if ifb1 ();

    assign ifa0.req = s_req[0];  assign ifa0.we = s_we[0];
    assign ifa0.addr = s_addr[0]; assign ifa0.wdata = s_wdata[0];
    assign ifa1.req = s_req[1];  assign ifa1.we = s_we[1];
    assign ifa1.addr = s_addr[1]; assign ifa1.wdata = s_wdata[1];
    assign ifb0.req = s_req[0];  assign ifb0.we = s_we[0];
    assign ifb0.addr = s_addr[0]; assign ifb0.wdata = s_wdata[0];
    assign ifb1.req = s_req[1];  assign ifb1.we = s_we[1];
    assign ifb1.addr = s_addr[1]; assign ifb1.wdata = s_wdata[1];

    assign ack0[0] = ifa0.ack; assign rdata0[0] = ifa0.rdata;
    assign ack1[0] = ifa1.ack; assign rdata1[0] = ifa1.rdata;
    assign ack0[1] = ifb0.ack; assign rdata0[1] = ifb0.rdata;
    assign ack1[1] = ifb1.ack; assign rdata1[1] = ifb1.rdata;

    mem_arbiter #(.RAM_LATENCY(LAT0)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .m0_if       (ifa0),
        .m1_if       (ifa1),
        .o_ram_en    (ram_en[0]),
        .o_ram_we    (ram_we[0]),
        .o_ram_addr  (ram_addr[0]),
        .o_ram_wdata (ram_wdata[0]),
        .i_ram_rdata (ram_rdata[0]),
        .o_busy      (busy[0]),
        .o_owner     (owner[0])
    );

    mem_arbiter #(.RAM_LATENCY(LAT1)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .m0_if       (ifb0),
        .m1_if       (ifb1),
        .o_ram_en    (ram_en[1]),
        .o_ram_we    (ram_we[1]),
        .o_ram_addr  (ram_addr[1]),
        .o_ram_wdata (ram_wdata[1]),
        .i_ram_rdata (ram_rdata[1]),
        .o_busy      (busy[1]),
        .o_owner     (owner[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_init(input int a);
        return 8'(a * 37 + 11);
    endfunction

    // ---------------- RAM models (one per instance) ----------------
    logic [7:0] ram  [2][256];
    logic [7:0] pipe [2][4];

    assign ram_rdata[0] = pipe[0][LAT0-1];
    assign ram_rdata[1] = pipe[1][LAT1-1];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) ram[k][i] = mem_init(i);
            for (int j = 0; j < 4; j++) pipe[k][j] = 8'h00;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ram_en[k] && ram_we[k]) ram[k][ram_addr[k]] = ram_wdata[k];
                // Garbage on the data lines whenever no read is landing.
                pipe[k][0] <= (ram_en[k] && !ram_we[k]) ? ram[k][ram_addr[k]] : 8'($urandom);
                for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
            end
        end
    end

    // ---------------- Transaction-level reference model ----------------
    // A transaction granted at an edge occupies cycles 1..dur after it
    // (dur = 2 for writes, 2 + latency for reads); cycle 1 drives the RAM,
    // cycle dur acknowledges, then one idle cycle follows.
    bit         m_act  [2];
    int         m_rel  [2];
    int         m_dur  [2];
    bit         m_mst  [2];
    bit         m_we   [2];
    bit         m_own  [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_wd   [2];
    logic [7:0] m_data [2];
    logic [7:0] m_rd   [2][2];
    logic [7:0] m_mem  [2][256];
    int unsigned m_lat [2] = '{LAT0, LAT1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0; m_rel[k] = 0; m_dur[k] = 0; m_mst[k] = 1'b0;
            m_we[k] = 1'b0; m_own[k] = 1'b1; m_addr[k] = 8'h00; m_wd[k] = 8'h00;
            m_rd[k][0] = 8'h00; m_rd[k][1] = 8'h00;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) m_mem[k][i] = mem_init(i);
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (m_act[k]) begin
                        m_rel[k]++;
                        if (m_rel[k] > m_dur[k]) m_act[k] = 1'b0;
                        else if (m_rel[k] == m_dur[k] && !m_we[k]) m_rd[k][m_mst[k]] = m_data[k];
                    end else if (s_req[0] || s_req[1]) begin
                        bit w;
                        w = (s_req[0] && s_req[1]) ? !m_own[k] : s_req[1];
                        m_own[k]  = w;
                        m_mst[k]  = w;
                        m_we[k]   = s_we[w];
                        m_addr[k] = s_addr[w];
                        m_wd[k]   = s_wdata[w];
                        m_act[k]  = 1'b1;
                        m_rel[k]  = 1;
                        m_dur[k]  = m_we[k] ? 2 : 2 + int'(m_lat[k]);
                        if (m_we[k]) m_mem[k][m_addr[k]] = m_wd[k];
                        else         m_data[k] = m_mem[k][m_addr[k]];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit e_en;
            bit e_ack;
            e_en  = m_act[k] && m_rel[k] == 1;
            e_ack = m_act[k] && m_rel[k] == m_dur[k];
            chk("ram_en",    k, 32'(ram_en[k]),    32'(e_en));
            chk("ram_we",    k, 32'(ram_we[k]),    32'(e_en && m_we[k]));
            chk("ram_addr",  k, 32'(ram_addr[k]),  32'(m_addr[k]));
            chk("ram_wdata", k, 32'(ram_wdata[k]), 32'(m_wd[k]));
            chk("busy",      k, 32'(busy[k]),      32'(m_act[k]));
            chk("owner",     k, 32'(owner[k]),     32'(m_own[k]));
            chk("m0_ack",    k, 32'(ack0[k]),      32'(e_ack && !m_mst[k]));
            chk("m1_ack",    k, 32'(ack1[k]),      32'(e_ack && m_mst[k]));
            chk("m0_rdata",  k, 32'(rdata0[k]),    32'(m_rd[k][0]));
            chk("m1_rdata",  k, 32'(rdata1[k]),    32'(m_rd[k][1]));
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check_all();
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy[0] || busy[1]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("idle_timeout", 0, 32'(busy[0] | busy[1]), 0);
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        s_req[m] = req; s_we[m] = we; s_addr[m] = addr; s_wdata[m] = wdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int q[$];
        for (int m = 0; m < 2; m++) drive(m, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_owner", k, 32'(owner[k]), 1);
            chk("rst_busy",  k, 32'(busy[k]),  0);
        end

        // m0 write 0x10 <- 0xA5
        wait_idle();
        drive(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            chk("t2_ram_en",    k, 32'(ram_en[k]),    1);
            chk("t2_ram_we",    k, 32'(ram_we[k]),    1);
            chk("t2_ram_addr",  k, 32'(ram_addr[k]),  32'h10);
            chk("t2_ram_wdata", k, 32'(ram_wdata[k]), 32'hA5);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t2_m0_ack",   k, 32'(ack0[k]),   1);
            chk("t2_m0_rdata", k, 32'(rdata0[k]), 0);
        end

        // m1 read 0x10: ack at cycle 3 (latency 1) and cycle 5 (latency 3)
        wait_idle();
        drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) chk("t3_ram_we", k, 32'(ram_we[k]), 0);
        repeat (2) @(negedge clk);
        chk("t3_m1_ack",   0, 32'(ack1[0]),   1);
        chk("t3_m1_rdata", 0, 32'(rdata1[0]), 32'hA5);
        chk("t3_m1_ack_early", 1, 32'(ack1[1]), 0);
        repeat (2) @(negedge clk);
        chk("t3_m1_ack",   1, 32'(ack1[1]),   1);
        chk("t3_m1_rdata", 1, 32'(rdata1[1]), 32'hA5);

        // m1 drops req while the latency-3 instance is in WAIT
        wait_idle();
        drive(1, 1'b1, 1'b0, 8'h33, 8'h00);
        acks = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
            if (ack1[1]) acks++;
            if (c == 5) chk("t5_m1_ack", 1, 32'(ack1[1]), 1);
            if (c == 6) chk("t5_busy",   1, 32'(busy[1]), 0);
        end
        chk("t5_ack_count", 1, 32'(acks), 1);
        chk("t5_m1_rdata",  1, 32'(rdata1[1]), 32'h6A);

        // Reset during WAIT, then a normal m0 read
        wait_idle();
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_ram_en",   k, 32'(ram_en[k]),   0);
            chk("t6_busy",     k, 32'(busy[k]),     0);
            chk("t6_owner",    k, 32'(owner[k]),    1);
            chk("t6_ack",      k, 32'({ack0[k], ack1[k]}), 0);
            chk("t6_m1_rdata", k, 32'(rdata1[k]),   0);
            chk("t6_ram_addr", k, 32'(ram_addr[k]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("t6_m0_ack",   0, 32'(ack0[0]),   1);
        chk("t6_m0_rdata", 0, 32'(rdata0[0]), 32'hA5);
        repeat (2) @(negedge clk);
        chk("t6_m0_ack",   1, 32'(ack0[1]),   1);
        chk("t6_m0_rdata", 1, 32'(rdata0[1]), 32'hA5);

        // Both masters requesting continuously from reset: strict alternation
        wait_idle();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h21, 8'h00);
        for (int c = 0; c < 300 && q.size() < 6; c++) begin
            @(negedge clk);
            if (ack0[0]) q.push_back(0);
            if (ack1[0]) q.push_back(1);
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t4_grant_count", 0, 32'(q.size()), 6);
        for (int i = 0; i < q.size(); i++) chk("t4_grant_order", 0, 32'(q[i]), 32'(i % 2));

        // Randomised traffic, checked by the model every cycle
        wait_idle();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                drive(m, ($urandom % 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                      8'($urandom));
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
